// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin arbiter sharing one synchronous image ROM among drawing layers
//
// Purpose: accepts at most one ROM read per pixel-clock cycle from N_REQ
// requesters, issues it to a single-port synchronous ROM, and returns the
// registered data to the requester that issued it with a one-hot strobe.
// The owner of each read is tracked by a pipeline that matches the ROM latency.
//
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   req        per-requester read request, held until granted
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        combinational one-hot grant
//   rom_en     registered ROM read enable
//   rom_addr   registered ROM address
//   rom_data   ROM output, valid RD_LAT cycles after rom_en
//   rd_valid   registered one-hot return strobe
//   rd_data    registered read data, qualified by rd_valid
//   idle       registered, high when no request and no read in flight
//
// Optional feature: define ROM_ARB_PRIO0_EN to give requester 0 fixed top
// priority; the remaining requesters round-robin while req[0] is low.

module rom_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    idle
);

  localparam int LAST_W = $clog2(N_REQ);
  localparam int PIPE_D = RD_LAT + 1;

  logic [LAST_W-1:0] last;
  logic [LAST_W-1:0] cand;
  logic [LAST_W-1:0] win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              accept;
  logic              hold_last;
  logic [PIPE_D-1:0] pipe_v;
  logic [LAST_W-1:0] pipe_idx [PIPE_D];
  logic [N_REQ-1:0]  ret_onehot;

  // Grant search: scan from last+1 upward with wrap; the first requester
  // found wins. Depends only on req, last and rst, never on addresses.
  always_comb begin
    gnt       = '0;
    cand      = '0;
    win_idx   = '0;
    win_addr  = '0;
    accept    = 1'b0;
    hold_last = 1'b0;
    if (!rst) begin
`ifdef ROM_ARB_PRIO0_EN
      // Requester 0 pre-empts the rotation and does not move the pointer.
      if (req[0]) begin
        accept    = 1'b1;
        hold_last = 1'b1;
        win_idx   = '0;
        win_addr  = req_addr[ADDR_W-1:0];
      end
`endif
      for (int k = 1; k <= N_REQ; k++) begin
        cand = LAST_W'((int'(last) + k) % N_REQ);
        if (!accept && req[cand]) begin
          accept   = 1'b1;
          win_idx  = cand;
          win_addr = req_addr[int'(cand)*ADDR_W +: ADDR_W];
        end
      end
      if (accept) begin
        gnt[win_idx] = 1'b1;
      end
    end
  end

  assign ret_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pipe_idx[PIPE_D-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= LAST_W'(N_REQ - 1);
      rom_en   <= 1'b0;
      rom_addr <= '0;
      pipe_v   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      idle     <= 1'b1;
    end else begin
      if (accept && !hold_last) begin
        last <= win_idx;
      end
      rom_en <= accept;
      if (accept) begin
        rom_addr <= win_addr;
      end
      // Stage 0 lines up with rom_en; the last stage lines up with rom_data.
      pipe_v   <= {pipe_v[PIPE_D-2:0], accept};
      rd_valid <= pipe_v[PIPE_D-1] ? ret_onehot : '0;
      if (pipe_v[PIPE_D-1]) begin
        rd_data <= rom_data;
      end
      idle <= (req == '0) && (pipe_v == '0);
    end
  end

  // Owner indices need no reset: they are only read when the matching valid is set.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= win_idx;
    for (int j = 1; j < PIPE_D; j++) begin
      pipe_idx[j] <= pipe_idx[j-1];
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter

module tb_rom_port_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    rom_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    idle;

  int n_tests = 0;
  int n_fail  = 0;

  rom_port_arbiter #(
    .N_REQ (N_REQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_addr(req_addr),
    .gnt     (gnt),
    .rom_en  (rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .idle    (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return a ^ 12'hA5C;
  endfunction

  // ROM with RD_LAT register stages.
  logic [DATA_W-1:0] rom_s [RD_LAT];
  always @(posedge clk) begin
    rom_s[0] <= rom_fn(rom_addr);
    for (int i = 1; i < RD_LAT; i++) rom_s[i] <= rom_s[i-1];
  end
  assign rom_data = rom_s[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          idx;
    logic [11:0] data;
  } ret_t;

  ret_t        q[$];
  int          ncyc     = 0;
  int          last_m   = N_REQ - 1;
  int          widx;
  bit          armed    = 0;
  logic [3:0]  eg, erv;
  logic        exp_en   = 0;
  logic [11:0] exp_addr = 0;
  logic [11:0] exp_rdd  = 0;
  logic        exp_idle = 1;

  always @(negedge clk) begin
    ncyc++;
    eg   = '0;
    widx = -1;
    if (!rst) begin
`ifdef ROM_ARB_PRIO0_EN
      if (req[0]) widx = 0;
`endif
      for (int k = 1; k <= N_REQ && widx < 0; k++) begin
        if (req[(last_m + k) % N_REQ]) widx = (last_m + k) % N_REQ;
      end
      if (widx >= 0) eg = 4'(1 << widx);
    end
    check("gnt", 32'(gnt), 32'(eg));

    erv = '0;
    if (q.size() > 0 && q[0].due == ncyc) begin
      erv     = 4'(1 << q[0].idx);
      exp_rdd = q[0].data;
      void'(q.pop_front());
    end
    if (armed) begin
      check("rd_valid", 32'(rd_valid), 32'(erv));
      check("rd_data", 32'(rd_data), 32'(exp_rdd));
      check("rom_en", 32'(rom_en), 32'(exp_en));
      check("rom_addr", 32'(rom_addr), 32'(exp_addr));
      check("idle", 32'(idle), 32'(exp_idle));
    end

    if (rst) begin
      armed    = 1;
      last_m   = N_REQ - 1;
      q.delete();
      exp_en   = 0;
      exp_addr = 0;
      exp_rdd  = 0;
      exp_idle = 1;
    end else begin
      exp_idle = (req == 0) && (q.size() == 0);
      exp_en   = (widx >= 0);
      if (widx >= 0) begin
        exp_addr = req_addr[widx*ADDR_W +: ADDR_W];
        q.push_back('{ncyc + RD_LAT + 2, widx, rom_fn(exp_addr)});
`ifdef ROM_ARB_PRIO0_EN
        if (!req[0]) last_m = widx;
`else
        last_m = widx;
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [11:0] base);
    for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = base + 12'(i * 'h11);
  endtask

  logic [3:0]  g [12];
  logic [3:0]  v [12];
  logic [11:0] d [12];
  logic [3:0]  exp_alt [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
  logic [3:0]  pats [12] = '{4'h5, 4'h5, 4'h3, 4'h9, 4'h6, 4'hC, 4'h7, 4'hB, 4'h0, 4'hF, 4'h1, 4'h8};

  initial begin
    rst = 1; req = '0; req_addr = '0;
    for (int i = 0; i < 3; i++) begin
      req = 4'($urandom);
      req_addr = 48'({$urandom, $urandom});
      #1 check("rst_gnt_zero", 32'(gnt), 0);
      step();
    end
    rst = 0; req = '0;
    #1;
    check("post_rst_rom_en", 32'(rom_en), 0);
    check("post_rst_rd_valid", 32'(rd_valid), 0);
    check("post_rst_rd_data", 32'(rd_data), 0);
    check("post_rst_idle", 32'(idle), 1);
    step();

    // single read from requester 2
    req = 4'b0100;
    req_addr[2*ADDR_W +: ADDR_W] = 12'h123;
    #1 check("single_gnt", 32'(gnt), 32'h4);
    step();
    req = '0;
    #1;
    check("single_rom_en", 32'(rom_en), 1);
    check("single_rom_addr", 32'(rom_addr), 32'h123);
    step(); step(); step();
    check("single_rd_valid", 32'(rd_valid), 32'h4);
    check("single_rd_data", 32'(rd_data), 32'hB7F);
    step(); step(); step();
    check("single_idle", 32'(idle), 1);

    // all four requesters held
    rst = 1; step(); rst = 0;
    set_addrs(12'h100);
    for (int i = 0; i < 12; i++) begin
      req = (i < 8) ? 4'hF : 4'h0;
      #1;
      g[i] = gnt; v[i] = rd_valid; d[i] = rd_data;
      step();
    end
`ifndef ROM_ARB_PRIO0_EN
    for (int i = 0; i < 8; i++) begin
      check("rr4_gnt", 32'(g[i]), 32'(1 << (i % 4)));
      check("rr4_rd_valid", 32'(v[i+4]), 32'(1 << (i % 4)));
      check("rr4_rd_data", 32'(d[i+4]), 32'(rom_fn(12'h100 + 12'((i % 4) * 'h11))));
    end
`endif

    // requester 1 wins, then 1 and 3 alternate
    req = 4'b0010; step();
    for (int i = 0; i < 4; i++) begin
      req = 4'b1010;
      #1 g[i] = gnt;
      step();
    end
    req = '0;
    for (int i = 0; i < 4; i++) check("alt_1_3_gnt", 32'(g[i]), 32'(exp_alt[i]));
    for (int i = 0; i < 6; i++) step();

    // reset with three reads in flight
    set_addrs(12'h2A0);
    req = 4'hF; step(); step(); step();
    rst = 1; req = '0; step();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      #1 check("rst_discard_rd_valid", 32'(rd_valid), 0);
      step();
    end
    req = 4'hF;
    #1 check("rst_first_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // mixed request patterns, checked by the model every cycle
    for (int i = 0; i < 12; i++) begin
      set_addrs(12'(12'h300 + i * 'h2B));
      req = pats[i];
      step();
    end
    req = '0;

`ifdef ROM_ARB_PRIO0_EN
    for (int i = 0; i < 6; i++) step();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      req = 4'b0111;
      #1 check("prio0_gnt0", 32'(gnt), 32'h1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      req = 4'b0110;
      #1 check("prio0_alt_1_2", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
      step();
    end
    req = '0;
`endif

    for (int i = 0; i < 8; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 expected");
    $fatal(1);
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Round-robin arbiter that shares one single-port synchronous image ROM between several drawing requesters, such as background, sprite and text layers, inside the `top_vga` pixel-clock domain. It accepts at most one read per cycle. It tracks the owner of every in-flight read through a latency-matched pipeline and returns registered data with a one-hot valid to the requester that issued the read. It runs entirely on the pixel clock produced by the clock wizard.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ADDR_W`, default 12: ROM address width.
- `DATA_W`, default 12: ROM word width (RGB444).
- `RD_LAT`, default 2: ROM read latency in cycles from `rom_addr`/`rom_en` to `rom_data`, range 1..4.

Ports:
- `clk`  in  1: pixel clock. This is the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N_REQ: read request per requester. It is held until granted.
- `req_addr`  in  N_REQ*ADDR_W: requester i address at bits `[i*ADDR_W +: ADDR_W]`. It is held stable while `req[i]` is high.
- `gnt`  out  N_REQ: combinational one-hot grant. It is all-zero when `req` is zero.
- `rom_en`  out  1: registered ROM read enable.
- `rom_addr`  out  ADDR_W: registered ROM address.
- `rom_data`  in  DATA_W: ROM output, valid `RD_LAT` cycles after `rom_en`.
- `rd_valid`  out  N_REQ: registered one-hot return strobe.
- `rd_data`  out  DATA_W: registered read data, shared by all requesters and qualified by `rd_valid`.
- `idle`  out  1: registered. High when `req` is zero and no read is in flight.

## Operation
- Accept: a read is accepted in a cycle where `req[i] & gnt[i]`. There is exactly one accept per cycle at most, and a requester may drop `req` on the cycle after its accept or keep it high for back-to-back reads.
- Round-robin: a pointer `last` (width clog2(N_REQ)) holds the index of the last winner.
  - The search starts at `(last+1) mod N_REQ` and wraps around.
  - After an accept, `last` is set to the winner.
  - Without requests, `last` holds.
  - The reset value of `last` is `N_REQ-1`, so requester 0 wins first.
- Issue: on the edge after an accept, `rom_en` goes to 1 and `rom_addr` takes the winner's address slice. With no accept, `rom_en` goes to 0 and `rom_addr` holds its value.
- Owner pipeline: a shift register `RD_LAT+1` stages deep carries {valid, index}. Stage 0 is loaded at accept.
- Return: when the last stage is valid, the next edge sets `rd_data` to `rom_data` and `rd_valid` to one-hot(index). Otherwise `rd_valid` is 0 and `rd_data` holds.
- Return order equals accept order. No reordering, no back-pressure: requesters must sink data on the `rd_valid` cycle.
- `idle` is 0 while any pipeline stage is valid or `req` is non-zero.
- Reset values: `rom_en`=0, `rom_addr`=0, `rd_valid`=0, `rd_data`=0, `idle`=1, all pipeline valids 0, `last`=N_REQ-1.
- Reset mid-operation: all in-flight reads are discarded and no `rd_valid` fires for them. `gnt` is forced to 0 while `rst` is high.
- Simultaneous requests: exactly one is granted. A newly rising `req` is treated the same as a held one.

## Timing
- Accept in cycle t: `rom_en`/`rom_addr` are valid in cycle t+1, `rom_data` in t+1+RD_LAT, and `rd_valid`/`rd_data` in t+2+RD_LAT. Total latency is RD_LAT+2 cycles.
- Throughput is one read per cycle sustained, with full-rate pipelining across any requester mix.
- `gnt` is combinational from `req`, `last` and `rst`. It must not depend on `req_addr`.

## Configuration
- `ROM_ARB_PRIO0_EN` defined: requester 0 has fixed top priority.
  - Whenever `req[0]` is high it is granted and `last` is unchanged.
  - Requesters 1..N_REQ-1 round-robin among themselves only when `req[0]` is low.
  - Starvation of the other requesters under continuous `req[0]` is accepted.
- Not defined: plain round-robin over all requesters as described above.

## Test plan
- Reset: hold `rst` for 3 cycles with random `req` -> `gnt`=0 throughout. The cycle after release with `req`=0 shows `rom_en`=0, `rd_valid`=0, `rd_data`=0, `idle`=1.
- Single read, RD_LAT=2: `req[2]`=1 with addr 0x123 for one cycle t -> `gnt`=4'b0100 at t; `rom_en`=1 and `rom_addr`=0x123 at t+1; `rd_valid`=4'b0100 with `rd_data`=ROM[0x123] at t+4; `idle`=1 afterwards.
- All four requesters held high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle. `rd_valid` repeats the same order 4 cycles later with matching data.
- `req`=4'b1010 held after requester 1 has won -> grants 3,1,3,1. No grant to 0 or 2.
- `rst` pulsed 1 cycle while 3 reads are in flight -> no `rd_valid` in the following 6 cycles. With `req`=4'b1111, the first grant after reset goes to 0.
- `ROM_ARB_PRIO0_EN` defined, `req`=4'b0111 for 4 cycles, then `req[0]` dropped -> `gnt[0]` in 4 consecutive cycles, then grants alternate 1,2,1,2.
